ai_i2s_bit_deserializer: RTL

Receive-side counterpart of the I2S transmit serializer. It samples the serial data line (SD) and the word-select line (WS) on each bit-clock strobe and finds channel boundaries from WS transitions, honouring the standard one-bit I2S delay. It assembles MSB-first words of a programmable length and presents each word, with its channel tag, on a valid/ready output register. It sits between the I2S pin-sampling/clock-recovery logic and the RX FIFO.

---
 rtl/ai_i2s_bit_deserializer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ai_i2s_bit_deserializer.sv
// ---------------------------------------------------------------------------
// ai_i2s_bit_deserializer
//
// Receive-side I2S bit deserializer. On every bit-clock strobe it samples the
// serial data line and the word-select line, finds channel boundaries from WS
// transitions (honouring the one-bit I2S delay), assembles MSB-first words of
// a programmable length and presents each finished word, with its channel
// tag, in a valid/ready output register.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   enable     block enable; low clears the block back to IDLE synchronously
//   clk_en     one-cycle sample strobe, one per SCK rising edge
//   ws_in      word select (0 = left, 1 = right), synchronous to clk
//   sd_in      serial data, synchronous to clk
//   num_bits   word length 1..DATA_WIDTH (larger clamps, 0 = no capture)
//   rx_data    received word, MSB-aligned, unused LSBs zero
//   rx_right   channel tag of rx_data (1 = right)
//   rx_valid   rx_data/rx_right hold an unconsumed word
//   rx_ready   consumer takes the word this cycle when rx_valid is high
//   busy       high while a word is being assembled
//   overrun    one-cycle pulse: a finished word was dropped, output was full
//   short_err  one-cycle pulse: WS edge arrived before the word was complete
// ---------------------------------------------------------------------------
module ai_i2s_bit_deserializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clk_en,
  input  logic                  ws_in,
  input  logic                  sd_in,
  input  logic [5:0]            num_bits,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_right,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  short_err
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [5:0] NB_MAX = 6'(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] sreg_shifted;
  logic [5:0]            cnt;
  logic [5:0]            cnt_inc;
  logic [5:0]            nb_lat;
  logic [5:0]            nb_clamped;
  logic                  chan;
  logic                  ws_prev;
  logic                  ws_prev_valid;
  logic                  ws_edge;
  logic                  can_load;

  // Per-strobe helper values: the shift register with this strobe's bit
  // written at the current MSB-first position, the incremented bit count,
  // the clamped word length and the WS edge detect. The output register can
  // take a new word if it is empty or being consumed in the same cycle.
  always_comb begin
    sreg_shifted = sreg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == DATA_WIDTH - 1 - int'(cnt)) begin
        sreg_shifted[i] = sd_in;
      end
    end
    cnt_inc    = cnt + 6'd1;
    nb_clamped = (num_bits > NB_MAX) ? NB_MAX : num_bits;
    ws_edge    = ws_prev_valid && (ws_in != ws_prev);
    can_load   = !rx_valid || rx_ready;
  end

  // Main state machine. Within one strobe the shift and completion are
  // evaluated first and a WS edge is evaluated last, so that with a slot as
  // long as the word the previous word completes on the very strobe that
  // starts the next one (the edge strobe carries the previous LSB).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sreg          <= '0;
      cnt           <= '0;
      nb_lat        <= '0;
      chan          <= 1'b0;
      ws_prev       <= 1'b0;
      ws_prev_valid <= 1'b0;
      rx_data       <= '0;
      rx_right      <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
      short_err     <= 1'b0;
    end else if (!enable) begin
      // Disabling discards any pending word and forgets the WS history so
      // that re-enabling cannot see a false edge.
      state         <= IDLE;
      sreg          <= '0;
      cnt           <= '0;
      ws_prev_valid <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
      short_err     <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      short_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (state == IDLE) begin
        state <= SYNC;
      end else if (clk_en) begin
        ws_prev       <= ws_in;
        ws_prev_valid <= 1'b1;
        if (state == SHIFT) begin
          sreg <= sreg_shifted;
          cnt  <= cnt_inc;
          if (cnt_inc == nb_lat) begin
            state <= HOLD;
            if (can_load) begin
              rx_data  <= sreg_shifted;
              rx_right <= chan;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        if (ws_edge) begin
          if ((state == SHIFT) && (cnt_inc < nb_lat)) begin
            short_err <= 1'b1;
          end
          sreg   <= '0;
          cnt    <= '0;
          chan   <= ws_in;
          nb_lat <= nb_clamped;
          state  <= (nb_clamped == 6'd0) ? HOLD : SHIFT;
        end
      end
    end
  end

  // busy is decoded straight from the state register, so it carries no
  // combinational path from the inputs.
  assign busy = (state == SHIFT);

endmodule
